// File: rtl/elf_pkg.sv
// Shared definitions for the CDP1802 DMA-in path: CPU state codes and the
// DMA-in controller state encoding.
package elf_pkg;

  localparam logic [1:0] SC_FETCH = 2'b00;
  localparam logic [1:0] SC_EXEC  = 2'b01;
  localparam logic [1:0] SC_DMA   = 2'b10;
  localparam logic [1:0] SC_INT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_XFER = 2'b10
  } dma_state_t;

endpackage

// File: rtl/elf_byte_fifo.sv
// Circular byte FIFO with power-of-two depth; a push coinciding with a pop
// is accepted even when full, since a slot frees on the same edge.
module elf_byte_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    head_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          do_push;
  logic          do_pop;
  logic [AW:0]   count_nxt;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointers are exactly AW bits, so increment wraps modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= din;
  end

  assign head_data = mem[head];

endmodule

// File: rtl/elf_dma_in.sv
// DMA-in source for the CDP1802: queues bytes from a loader/keypad and
// delivers them one per granted DMA cycle, retrying on aborted grants.
module elf_dma_in
  import elf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_enable,
  input  logic          enable,
  input  logic [7:0]    byte_in,
  input  logic          byte_wr,
  input  logic [1:0]    sc,
  input  logic          mem_write,
  output logic          dma_in_req,
  output logic [7:0]    dma_data,
  output logic          dma_oe,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow
);

  dma_state_t state;
  dma_state_t state_nxt;
  logic [7:0] head_data;
  logic       push;
  logic       pop;
  logic       more;

  assign push = byte_wr & clk_enable;
  assign pop  = (state == ST_XFER) & clk_enable & (sc == SC_DMA) & mem_write & ~empty;
  assign more = (count > (AW+1)'(1));

  elf_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .din       (byte_in),
    .head_data (head_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    overflow <= 1'b0;
    else if (push & full & ~pop)  overflow <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           state <= ST_IDLE;
    else if (clk_enable) state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    dma_in_req = 1'b0;
    dma_oe     = 1'b0;
    dma_data   = 8'h00;
    case (state)
      ST_IDLE: begin
        if (enable && !empty) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        dma_in_req = 1'b1;
        if (!enable)           state_nxt = ST_IDLE;
        else if (sc == SC_DMA) state_nxt = ST_XFER;
      end
      ST_XFER: begin
        dma_oe     = 1'b1;
        dma_data   = head_data;
        dma_in_req = more;
        // enable is ignored until the write lands so a transfer is never cut short
        if (sc == SC_DMA && mem_write) state_nxt = (more && enable) ? ST_REQ : ST_IDLE;
        else if (sc != SC_DMA)         state_nxt = ST_REQ;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_elf_dma_in.sv
// Directed bench for elf_dma_in: stimulus pushes expected bytes into a queue,
// a negedge monitor checks every byte the DUT writes in a DMA cycle.
module tb_elf_dma_in;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_enable;
  logic       enable;
  logic [7:0] byte_in;
  logic       byte_wr;
  logic [1:0] sc;
  logic       mem_write;
  logic       dma_in_req;
  logic [7:0] dma_data;
  logic       dma_oe;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int pops    = 0;
  logic [7:0] exp_q [$];

  elf_dma_in #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .enable     (enable),
    .byte_in    (byte_in),
    .byte_wr    (byte_wr),
    .sc         (sc),
    .mem_write  (mem_write),
    .dma_in_req (dma_in_req),
    .dma_data   (dma_data),
    .dma_oe     (dma_oe),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a DMA write happens on the next edge whenever XFER sees a grant.
  always @(negedge clk) begin
    if (!reset) begin
      if (!dma_oe) chk("dma_data_idle", dma_data, 8'h00);
      else if (sc == 2'b10 && mem_write && clk_enable) begin
        if (exp_q.size() == 0) chk("unexpected_byte", dma_data, 32'hFFFF_FFFF);
        else chk("dma_byte", dma_data, exp_q.pop_front());
        chk("req_in_xfer", dma_in_req, (count > 3'd1) ? 1 : 0);
        pops++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] b, input bit accepted);
    byte_in = b; byte_wr = 1'b1;
    tick();
    byte_wr = 1'b0;
    if (accepted) exp_q.push_back(b);
  endtask

  task automatic wait_req(input string name);
    int i;
    for (i = 0; i < 10 && !dma_in_req; i++) tick();
    chk(name, dma_in_req, 1);
  endtask

  task automatic grant(input int n);
    int target = pops + n;
    sc = 2'b10; mem_write = 1'b1;
    for (int i = 0; i < 20 * n; i++) begin
      tick();
      if (pops >= target) break;
    end
    if (pops < target) chk("grant_timeout", pops, target);
    sc = 2'b00; mem_write = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    tick();
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b1; enable = 1'b0; byte_in = 8'h00;
    byte_wr = 1'b0; sc = 2'b00; mem_write = 1'b0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_req", dma_in_req, 0);
    chk("rst_oe", dma_oe, 0);
    tick(); reset = 1'b0; tick();

    // single byte
    enable = 1'b1;
    push(8'hA5, 1);
    wait_req("a5_req");
    grant(1);
    chk("a5_empty", empty, 1);
    chk("a5_req_low", dma_in_req, 0);

    // clk_enable low blocks pushes
    clk_enable = 1'b0;
    push(8'hEE, 0);
    clk_enable = 1'b1;
    chk("ce_count", count, 0);

    // three back-to-back
    push(8'h11, 1); push(8'h22, 1); push(8'h33, 1);
    chk("three_count", count, 3);
    wait_req("three_req");
    grant(3);
    chk("three_count0", count, 0);
    chk("three_empty", empty, 1);

    // overflow: 5 pushes into depth 4
    push(8'h41, 1); push(8'h42, 1); push(8'h43, 1); push(8'h44, 1); push(8'h45, 0);
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 4);
    grant(4);
    chk("ovf_drained", empty, 1);
    chk("ovf_sticky", overflow, 1);
    do_reset();
    chk("ovf_cleared", overflow, 0);

    // abort then retry
    enable = 1'b1;
    push(8'h5C, 1); push(8'h6D, 1);
    wait_req("abort_req");
    sc = 2'b10; mem_write = 1'b0;
    tick();
    chk("abort_oe", dma_oe, 1);
    sc = 2'b00;
    tick();
    chk("abort_back_req", dma_in_req, 1);
    chk("abort_count", count, 2);
    grant(1);
    chk("retry_count", count, 1);
    grant(1);
    chk("retry_empty", empty, 1);

    // enable gating
    enable = 1'b0;
    push(8'h7A, 1); push(8'h7B, 1);
    repeat (5) tick();
    chk("gate_req", dma_in_req, 0);
    chk("gate_count", count, 2);
    enable = 1'b1;
    wait_req("gate_req_on");
    grant(2);
    chk("gate_empty", empty, 1);

    // push at the pop edge while full
    push(8'h81, 1); push(8'h82, 1); push(8'h83, 1); push(8'h84, 1);
    wait_req("wrap_req");
    sc = 2'b10; mem_write = 1'b1;
    for (int i = 0; i < 10 && !dma_oe; i++) tick();
    chk("wrap_oe", dma_oe, 1);
    byte_in = 8'h99; byte_wr = 1'b1;
    exp_q.push_back(8'h99);
    tick();
    byte_wr = 1'b0; sc = 2'b00; mem_write = 1'b0;
    chk("wrap_count", count, 4);
    chk("wrap_full", full, 1);
    chk("wrap_ovf", overflow, 0);
    grant(4);
    chk("wrap_empty", empty, 1);

    // reset during XFER
    push(8'hC3, 1);
    wait_req("rstx_req");
    sc = 2'b10; mem_write = 1'b0;
    tick();
    chk("rstx_in_xfer", dma_oe, 1);
    reset = 1'b1;
    #1;
    chk("rstx_oe", dma_oe, 0);
    chk("rstx_req", dma_in_req, 0);
    chk("rstx_data", dma_data, 8'h00);
    chk("rstx_count", count, 0);
    chk("rstx_empty", empty, 1);
    exp_q.delete();
    sc = 2'b00;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("rstx_stay_idle", dma_in_req, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
